// File: rtl/lut_pkg.sv
// Shared definitions for the lut_sweeper truth-table engine.
// Latency: none (definitions only).
// Backpressure: not applicable.
package lut_pkg;

  // Sweep controller state encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Default geometry and table: f = (b&d)|(~c&~d), index {a,b,c,d}, a = MSB.
  localparam int          N_DEFAULT    = 4;
  localparam logic [15:0] INIT_DEFAULT = 16'hB1B1;

endpackage

// File: rtl/lut_sweep_ctrl.sv
// Sweep controller: walks every table index and streams (index, value) beats, counting ones.
// Latency: first beat in the cycle after start is sampled; done one cycle after the last transfer.
// Backpressure: out_valid/out_index/out_value hold stable while out_ready is low; nothing advances.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a sweep (sampled only in IDLE)
//   tbl             truth table being swept (frozen by the top while busy)
//   busy, done      sweep in progress / one-cycle completion pulse
//   ones_count      ones seen in the last sweep
//   out_valid/out_ready/out_index/out_value  beat stream
module lut_sweep_ctrl
  import lut_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [(1<<N)-1:0]   tbl,
  output logic                busy,
  output logic                done,
  output logic [N:0]          ones_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_index,
  output logic                out_value
);

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] counter_q;
  logic [N:0]   ones_q;
  logic         xfer;
  logic         last_beat;

  assign xfer      = out_valid & out_ready;
  assign last_beat = (counter_q == {N{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (xfer && last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter wraps to zero after the last beat, so out_index rests at 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      ones_q    <= '0;
    end else if (state_q == ST_IDLE && start) begin
      counter_q <= '0;
      ones_q    <= '0;
    end else if (xfer) begin
      counter_q <= counter_q + N'(1);
      ones_q    <= ones_q + (N+1)'(out_value);
    end
  end

  assign out_index  = counter_q;
  assign out_value  = tbl[counter_q];
  assign ones_count = ones_q;

endmodule

// File: rtl/lut_sweeper.sv
// Programmable N-input boolean function: registered truth-table lookup plus exhaustive sweep mode.
// Latency: eval_out is 1 clock after eval_in; sweep beats start 1 clock after start.
// Backpressure: sweep stream stalls with stable index/value while out_ready is low.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (table reloads INIT)
//   cfg_we, cfg_table load a new truth table (ignored while a sweep is running)
//   eval_in/eval_out  direct evaluation, eval_out = table[eval_in] registered
//   start, busy, done sweep control and status
//   ones_count        minterm count from the last sweep
//   out_*             (index, value) beat stream with valid/ready handshake
module lut_sweeper
  import lut_pkg::*;
#(
  parameter int                N    = N_DEFAULT,
  parameter logic [(1<<N)-1:0] INIT = INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [(1<<N)-1:0] cfg_table,
  input  logic [N-1:0]      eval_in,
  output logic              eval_out,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N:0]        ones_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_index,
  output logic              out_value
);

  logic [(1<<N)-1:0] table_q;

  // Table is frozen while a sweep runs so the count reflects one consistent function.
  always_ff @(posedge clk) begin
    if (rst) begin
      table_q <= INIT;
    end else if (cfg_we && !busy) begin
      table_q <= cfg_table;
    end
  end

  // Eval reads the pre-update table, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_out <= 1'b0;
    end else begin
      eval_out <= table_q[eval_in];
    end
  end

  lut_sweep_ctrl #(
    .N (N)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tbl        (table_q),
    .busy       (busy),
    .done       (done),
    .ones_count (ones_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_value  (out_value)
  );

endmodule
